// File: rtl/wash_timer.sv
// wash_timer: prescaled cycle/spin timeouts plus fill/drain valve watchdog
module wash_timer #(
    parameter int TICK_DIV      = 1000,
    parameter int CYCLE_SEC     = 8,
    parameter int SPIN_SEC      = 4,
    parameter int FILL_MAX_SEC  = 30,
    parameter int DRAIN_MAX_SEC = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cycle_run,
    input  logic       spin_run,
    input  logic       fillvalve,
    input  logic       drainvalve,
    input  logic       filled,
    input  logic       drained,
    input  logic       clr_fault,
    output logic       cycletout,
    output logic       spintout,
    output logic [7:0] time_left,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CYCLE   = 2'd1;
    localparam logic [1:0] S_SPIN    = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] CYC_LD  = 8'(CYCLE_SEC);
    localparam logic [7:0] SPN_LD  = 8'(SPIN_SEC);
    localparam logic [7:0] FILL_LIM  = 8'(FILL_MAX_SEC);
    localparam logic [7:0] DRAIN_LIM = 8'(DRAIN_MAX_SEC);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic          cycletout_q, cycletout_d;
    logic          spintout_q, spintout_d;
    logic [PW-1:0] wd_presc_q, wd_presc_d;
    logic [7:0]    fill_cnt_q, fill_cnt_d;
    logic [7:0]    drain_cnt_q, drain_cnt_d;
    logic          fault_q, fault_d;
    logic [1:0]    code_q, code_d;
    logic          run_act, wd_tick, fill_open, drain_open, fill_hit, drain_hit, record;

    // Timer FSM: the run input owning the active timer keeps it alive; sec_q is zero whenever no countdown is running
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        sec_d       = sec_q;
        cycletout_d = cycletout_q;
        spintout_d  = spintout_q;
        run_act     = (state_q == S_CYCLE || cycletout_q) ? cycle_run : spin_run;
        if (state_q == S_IDLE) begin
            if (cycle_run || spin_run) begin
                state_d = cycle_run ? S_CYCLE : S_SPIN;
                sec_d   = cycle_run ? CYC_LD : SPN_LD;
                presc_d = '0;
            end
        end else if (!run_act) begin
            state_d     = S_IDLE;
            presc_d     = '0;
            sec_d       = '0;
            cycletout_d = 1'b0;
            spintout_d  = 1'b0;
        end else if (state_q != S_EXPIRED) begin
            presc_d = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
            if (presc_q == P_LAST) begin
                sec_d = sec_q - 8'd1;
                if (sec_q == 8'd1) begin
                    state_d     = S_EXPIRED;
                    cycletout_d = (state_q == S_CYCLE);
                    spintout_d  = (state_q == S_SPIN);
                end
            end
        end
    end

    // Watchdog: free-running tick, saturating open-valve counters, first fault wins until cleared
    always_comb begin
        wd_tick     = (wd_presc_q == P_LAST);
        wd_presc_d  = wd_tick ? '0 : wd_presc_q + 1'b1;
        fill_open   = fillvalve & ~filled;
        drain_open  = drainvalve & ~drained;
        fill_hit    = fill_open & wd_tick & (fill_cnt_q == FILL_LIM - 8'd1);
        drain_hit   = drain_open & wd_tick & (drain_cnt_q == DRAIN_LIM - 8'd1);
        fill_cnt_d  = !fill_open ? 8'd0 : (wd_tick && fill_cnt_q != FILL_LIM) ? fill_cnt_q + 8'd1 : fill_cnt_q;
        drain_cnt_d = !drain_open ? 8'd0 : (wd_tick && drain_cnt_q != DRAIN_LIM) ? drain_cnt_q + 8'd1 : drain_cnt_q;
        record      = (fill_hit | drain_hit) & (clr_fault | ~fault_q);
        fault_d     = record | (fault_q & ~clr_fault);
        code_d      = record ? (fill_hit ? 2'b01 : 2'b10) : clr_fault ? 2'b00 : code_q;
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            sec_q       <= '0;
            cycletout_q <= 1'b0;
            spintout_q  <= 1'b0;
            wd_presc_q  <= '0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            fault_q     <= 1'b0;
            code_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            cycletout_q <= cycletout_d;
            spintout_q  <= spintout_d;
            wd_presc_q  <= wd_presc_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign cycletout  = cycletout_q;
    assign spintout   = spintout_q;
    assign time_left  = sec_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: directed and randomized checks of wash_timer against an elapsed-time reference model
module tb_wash_timer;
    localparam int TD = 4, CS = 3, SS = 2, FM = 2, DM = 2;

    logic clk = 0, rst_n = 0;
    logic cycle_run = 0, spin_run = 0, fillvalve = 0, drainvalve = 0;
    logic filled = 0, drained = 0, clr_fault = 0;
    logic cycletout, spintout, fault;
    logic [7:0] time_left;
    logic [1:0] fault_code;

    int checks = 0, errors = 0;
    int kind, e, n, fill_t, drain_t;
    bit m_fault;
    int m_code;
    int cnt;

    always #5 clk = ~clk;

    wash_timer #(.TICK_DIV(TD), .CYCLE_SEC(CS), .SPIN_SEC(SS), .FILL_MAX_SEC(FM), .DRAIN_MAX_SEC(DM)) dut (
        .clk(clk), .rst_n(rst_n), .cycle_run(cycle_run), .spin_run(spin_run),
        .fillvalve(fillvalve), .drainvalve(drainvalve), .filled(filled), .drained(drained),
        .clr_fault(clr_fault), .cycletout(cycletout), .spintout(spintout),
        .time_left(time_left), .fault(fault), .fault_code(fault_code)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim_of(input int k);
        return (k == 1) ? CS * TD : SS * TD;
    endfunction

    // Expected outputs derived from edges elapsed since the timer started
    function automatic int exp_tl();
        if (kind == 0 || e >= lim_of(kind)) return 0;
        return ((kind == 1) ? CS : SS) - e / TD;
    endfunction

    task automatic model_reset();
        kind = 0; e = 0; n = 0; fill_t = 0; drain_t = 0; m_fault = 0; m_code = 0;
    endtask

    task automatic model_edge();
        bit tick, fo, dop, fh, dh, run, rec;
        tick = (n % TD) == TD - 1;
        n++;
        if (kind == 0) begin
            if (cycle_run) begin kind = 1; e = 0; end
            else if (spin_run) begin kind = 2; e = 0; end
        end else begin
            run = (kind == 1) ? cycle_run : spin_run;
            if (!run) kind = 0;
            else if (e < lim_of(kind)) e++;
        end
        fo = fillvalve && !filled;
        dop = drainvalve && !drained;
        fill_t = fo ? fill_t + int'(tick) : 0;
        drain_t = dop ? drain_t + int'(tick) : 0;
        fh = fo && tick && fill_t == FM;
        dh = dop && tick && drain_t == DM;
        rec = (fh || dh) && (clr_fault || !m_fault);
        if (rec) begin m_fault = 1; m_code = fh ? 1 : 2; end
        else if (clr_fault) begin m_fault = 0; m_code = 0; end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cycletout", int'(cycletout), int'(kind == 1 && e == lim_of(1)));
            chk("spintout", int'(spintout), int'(kind == 2 && e == lim_of(2)));
            chk("time_left", int'(time_left), exp_tl());
            chk("fault", int'(fault), int'(m_fault));
            chk("fault_code", int'(fault_code), m_code);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cycletout", int'(cycletout), 0);
        chk("rst_time_left", int'(time_left), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1;
        // cycle timing
        cycle_run = 1;
        cyc(); chk("cyc_tl_e0", int'(time_left), 3);
        repeat (4) cyc(); chk("cyc_tl_e4", int'(time_left), 2);
        repeat (4) cyc(); chk("cyc_tl_e8", int'(time_left), 1);
        repeat (3) cyc(); chk("cyc_ct_e11", int'(cycletout), 0);
        cyc(); chk("cyc_ct_e12", int'(cycletout), 1);
        repeat (5) cyc(); chk("cyc_ct_hold", int'(cycletout), 1);
        cycle_run = 0;
        cyc(); chk("cyc_ct_fall", int'(cycletout), 0);
        // abort and restart
        cyc();
        cycle_run = 1;
        repeat (7) cyc();
        cycle_run = 0;
        cyc(); chk("abort_tl_e7", int'(time_left), 0);
        chk("abort_ct", int'(cycletout), 0);
        cycle_run = 1;
        repeat (12) cyc(); chk("restart_ct_e11", int'(cycletout), 0);
        cyc(); chk("restart_ct_e12", int'(cycletout), 1);
        cycle_run = 0;
        cyc();
        // priority then spin
        cycle_run = 1; spin_run = 1;
        cyc(); chk("prio_tl", int'(time_left), 3);
        repeat (12) cyc(); chk("prio_ct", int'(cycletout), 1);
        chk("prio_st", int'(spintout), 0);
        cycle_run = 0;
        cyc(); chk("prio_ct_drop", int'(cycletout), 0);
        cyc(); chk("spin_tl_e0", int'(time_left), 2);
        repeat (7) cyc(); chk("spin_st_e7", int'(spintout), 0);
        cyc(); chk("spin_st_e8", int'(spintout), 1);
        spin_run = 0;
        cyc(); chk("spin_st_fall", int'(spintout), 0);
        // fill watchdog
        fillvalve = 1;
        cnt = 0;
        while (!fault && cnt < 30) begin cyc(); cnt++; end
        chk("fill_window", int'(cnt >= 4 && cnt <= 12), 1);
        chk("fill_code", int'(fault_code), 1);
        drainvalve = 1;
        repeat (12) cyc(); chk("drain_keeps_code", int'(fault_code), 1);
        clr_fault = 1;
        cyc();
        clr_fault = 0;
        chk("clr_fault", int'(fault), 0);
        chk("clr_code", int'(fault_code), 0);
        fillvalve = 0; drainvalve = 0;
        cyc();
        // drained sensor keeps clearing the drain counter
        drainvalve = 1;
        for (int i = 0; i < 60; i++) begin
            drained = (i % 6) < 2;
            cyc();
        end
        chk("sensor_no_fault", int'(fault), 0);
        drainvalve = 0; drained = 0;
        cyc();
        // async reset mid-expired with fault set
        cycle_run = 1; fillvalve = 1;
        repeat (14) cyc();
        chk("pre_rst_ct", int'(cycletout), 1);
        chk("pre_rst_fault", int'(fault), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_ct", int'(cycletout), 0);
        chk("arst_fault", int'(fault), 0);
        chk("arst_code", int'(fault_code), 0);
        chk("arst_tl", int'(time_left), 0);
        model_reset();
        cycle_run = 0; fillvalve = 0;
        @(negedge clk);
        rst_n = 1;
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(24) == 0) cycle_run = ~cycle_run;
            if ($urandom_range(24) == 0) spin_run = ~spin_run;
            if ($urandom_range(29) == 0) fillvalve = ~fillvalve;
            if ($urandom_range(29) == 0) drainvalve = ~drainvalve;
            if ($urandom_range(19) == 0) filled = ~filled;
            if ($urandom_range(19) == 0) drained = ~drained;
            clr_fault = ($urandom_range(49) == 0);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
